// File: rtl/mux2_sel.sv
// Two-input WIDTH-bit selector with a combinational output and an enabled register copy.
// Optional sel-switch counter built only when MUX2_SWITCH_CNT_EN is defined.
module mux2_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sw_cnt
);

  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_q_r;
  logic             sel_q_r;

  // Ternary keeps an unknown sel propagating as X rather than favouring one input.
  always_comb begin
    y_s = sel ? b : a;
  end

  assign y = y_s;

  // Output register: loads the selected data and the select on every enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r   <= {WIDTH{1'b0}};
      sel_q_r <= 1'b0;
    end else if (en) begin
      y_q_r   <= y_s;
      sel_q_r <= sel;
    end else begin
      y_q_r   <= y_q_r;
      sel_q_r <= sel_q_r;
    end
  end

  assign y_q   = y_q_r;
  assign sel_q = sel_q_r;

`ifdef MUX2_SWITCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sel_prev_r;
  logic [CNT_W-1:0] sw_cnt_r;

  // Switch counter: samples sel every edge regardless of en and saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_r <= 1'b0;
      sw_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sel_prev_r <= sel;
      if ((sel != sel_prev_r) && (sw_cnt_r != CNT_MAX)) begin
        sw_cnt_r <= sw_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        sw_cnt_r <= sw_cnt_r;
      end
    end
  end

  assign sw_cnt = sw_cnt_r;
`else
  assign sw_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mux2_sel.sv
// Self-checking bench for mux2_sel: directed scenarios plus randomized traffic
// against a behavioural model; a WIDTH=1/CNT_W=2 and a WIDTH=8/CNT_W=8 instance.
module tb_mux2_sel;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       en;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       y1, yq1, selq1;
  logic [7:0] y8, yq8;
  logic       selq8;
  logic [1:0] sw1;
  logic [7:0] sw8;

  int n_checks = 0;
  int n_errors = 0;

  mux2_sel #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .en(en),
    .y(y1), .y_q(yq1), .sel_q(selq1), .sw_cnt(sw1)
  );

  mux2_sel #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel), .en(en),
    .y(y8), .y_q(yq8), .sel_q(selq8), .sw_cnt(sw8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model, integer-based
  int m_yq1, m_yq8, m_selq, m_prev, m_cnt1, m_cnt8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq1 <= 0; m_yq8 <= 0; m_selq <= 0; m_prev <= 0; m_cnt1 <= 0; m_cnt8 <= 0;
    end else begin
      if (en) begin
        m_yq1  <= (sel == 1'b1) ? int'(b1) : int'(a1);
        m_yq8  <= (sel == 1'b1) ? int'(b8) : int'(a8);
        m_selq <= int'(sel);
      end
      if (int'(sel) != m_prev) begin
        m_cnt1 <= (m_cnt1 + 1 > 3)   ? 3   : m_cnt1 + 1;
        m_cnt8 <= (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
      end
      m_prev <= int'(sel);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_sw(input int cnt);
`ifdef MUX2_SWITCH_CNT_EN
    return cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".y1"},    {31'd0, y1},    (sel == 1'b1) ? {31'd0, b1} : {31'd0, a1});
    check({tag, ".y8"},    {24'd0, y8},    (sel == 1'b1) ? {24'd0, b8} : {24'd0, a8});
    check({tag, ".yq1"},   {31'd0, yq1},   m_yq1);
    check({tag, ".yq8"},   {24'd0, yq8},   m_yq8);
    check({tag, ".selq1"}, {31'd0, selq1}, m_selq);
    check({tag, ".selq8"}, {31'd0, selq8}, m_selq);
    check({tag, ".sw1"},   {30'd0, sw1},   exp_sw(m_cnt1));
    check({tag, ".sw8"},   {24'd0, sw8},   exp_sw(m_cnt8));
  endtask

  task automatic drive(input logic s, input logic e, input logic ia, input logic ib,
                       input logic [7:0] ia8, input logic [7:0] ib8);
    @(negedge clk);
    sel = s; en = e; a1 = ia; b1 = ib; a8 = ia8; b8 = ib8;
  endtask

  task automatic edge_check(input string tag);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int exp_cnt5 [5];
    rst_n = 1'b0; sel = 1'b0; en = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #3;
    check("reset.yq1", {31'd0, yq1}, 32'd0);
    check("reset.selq1", {31'd0, selq1}, 32'd0);
    check("reset.sw1", {30'd0, sw1}, 32'd0);
    check("reset.yq8", {24'd0, yq8}, 32'd0);
    // Hold reset across an edge with en=1; registers must stay clear
    a1 = 1'b1; a8 = 8'hFF; en = 1'b1;
    @(posedge clk); #1;
    check("reset_hold.yq1", {31'd0, yq1}, 32'd0);
    check("reset_hold.yq8", {24'd0, yq8}, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1; en = 1'b0; a1 = 1'b0; a8 = 8'h00;

    // Combinational sweep, sel=0 then sel=1, {a,b} = 00,10,01,11
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        logic [1:0] ab;
        ab = 2'(k);
        @(negedge clk);
        sel = s[0]; a1 = ab[0]; b1 = ab[1];
        #2;
        check("sweep.y", {31'd0, y1}, (s == 1) ? {30'd0, ab[1]} : {30'd0, ab[0]});
      end
    end

    // Load then hold
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
    edge_check("load");
    check("load.yq1", {31'd0, yq1}, 32'd0);
    check("load.selq1", {31'd0, selq1}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'h44);
    edge_check("hold");
    check("hold.yq1", {31'd0, yq1}, 32'd0);
    check("hold.selq1", {31'd0, selq1}, 32'd1);
    check("hold.y1", {31'd0, y1}, 32'd1);
    check("hold.yq8", {24'd0, yq8}, 32'h22);

    // Async reset between edges
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h00);
    edge_check("preload");
    check("preload.yq1", {31'd0, yq1}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async.yq1", {31'd0, yq1}, 32'd0);
    check("async.selq1", {31'd0, selq1}, 32'd0);
    check("async.sw1", {30'd0, sw1}, 32'd0);
    check("async.yq8", {24'd0, yq8}, 32'd0);
    a1 = 1'b0; b1 = 1'b1; sel = 1'b1;
    #1;
    check("async.y1", {31'd0, y1}, 32'd1);
    sel = 1'b0; en = 1'b0;
    #1;
    rst_n = 1'b1;

    // Toggle sel on five edges: counter saturates at 3 on the CNT_W=2 instance
`ifdef MUX2_SWITCH_CNT_EN
    exp_cnt5 = '{1, 2, 3, 3, 3};
`else
    exp_cnt5 = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(~sel, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      edge_check("toggle");
      check("toggle.sw1", {30'd0, sw1}, exp_cnt5[i]);
    end

    // Wide datapath
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C);
    #2;
    check("wide.sel0", {24'd0, y8}, 32'hA5);
    sel = 1'b1; #1;
    check("wide.sel1", {24'd0, y8}, 32'h3C);
    en = 1'b1;
    edge_check("wide_load");
    check("wide_load.yq8", {24'd0, yq8}, 32'h3C);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2; rst_n = 1'b0; #1;
        check_all("rnd_rst");
        #1; rst_n = 1'b1;
      end
      edge_check("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
